pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage datapath. Each cycle it generates the write-enable and flush (bubble) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards, flushes on taken branches and jumps, and freezes the pipeline while a data-memory access is pending. It also keeps stall and flush statistics and a sticky memory-timeout error.

---
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage datapath: register enables,
// bubble injection, redirect control, memory-wait freeze and statistics.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             idex_MemRead,
    input  logic [4:0]       idex_Wreg_addr,
    input  logic             ex_branch_taken,
    input  logic             ex_jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pc_sel_target,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state_q, state_nxt;
    logic [WAIT_W-1:0] wait_q, wait_nxt;
    logic [CNT_W-1:0]  stall_q, flush_q;
    logic              err_q;

    logic       load_use, redirect, mem_busy;
    logic       decode_run;
    logic [4:0] we_c;          // {pc, ifid, idex, exmem, memwb}
    logic       ifid_flush_c, idex_flush_c, pc_sel_c;
    logic       stall_ev, flush_ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    assign load_use = idex_MemRead && (idex_Wreg_addr != 5'd0) &&
                      ((id_use_rs && (id_rs == idex_Wreg_addr)) ||
                       (id_use_rt && (id_rt == idex_Wreg_addr)));
    assign redirect = ex_branch_taken || ex_jump;
    assign mem_busy = mem_req && !mem_ready;

    always_comb begin
        state_nxt    = state_q;
        wait_nxt     = wait_q;
        decode_run   = 1'b0;
        we_c         = 5'b00000;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        pc_sel_c     = 1'b0;
        flush_ev     = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    // The freezing RUN cycle counts as the first wait cycle.
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    decode_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    wait_nxt = wait_q + WAIT_W'(1);
                    if (wait_q >= WAIT_LAST)
                        state_nxt = ERROR;
                end else begin
                    decode_run = 1'b1;
                    state_nxt  = RUN;
                    wait_nxt   = '0;
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase

        if (decode_run) begin
            if (redirect) begin
                we_c         = 5'b11111;
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
                pc_sel_c     = 1'b1;
                flush_ev     = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, push one bubble into ID/EX, let the rest drain.
                we_c         = 5'b00111;
                idex_flush_c = 1'b1;
            end else begin
                we_c = 5'b11111;
            end
        end

        stall_ev = !we_c[4] && (state_q != ERROR);
    end

    always_comb begin
        if (!RSTn) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b00000;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            pc_sel_target = 1'b0;
        end else begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = we_c;
            ifid_flush    = ifid_flush_c;
            idex_flush    = idex_flush_c;
            pc_sel_target = pc_sel_c;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
            stall_q <= sat_inc(stall_q, stall_ev);
            flush_q <= sat_inc(flush_q, flush_ev);
            if (state_nxt == ERROR)
                err_q <= 1'b1;
        end
    end

    assign mem_timeout_err = err_q;
    assign stall_cnt       = stall_q;
    assign flush_cnt       = flush_q;

endmodule
